// File: rtl/window_delay_line.sv
// window_delay_line: circular sample window feeding moving_sum with entering/leaving pairs
module window_delay_line #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int INIT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [ADDR_W-1:0] win_len,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              wr,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              init_wr,
    output logic [INIT_W-1:0] init_sum,
    output logic              filled
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]        state, state_nxt;
    logic              en_d;
    logic [ADDR_W-1:0] wptr, wptr_nxt, cnt, n_lat;
    logic [ADDR_W:0]   cnt_inc;
    logic              start, accept;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign init_sum = '0;

    // start on en rising edge in IDLE or on clr; a start cycle never accepts a sample
    always_comb begin
        start     = en && (clr || (state == IDLE && !en_d));
        accept    = en && !start && din_valid && state != IDLE;
        wptr_nxt  = (wptr == n_lat - ADDR_W'(1)) ? '0 : wptr + ADDR_W'(1);
        cnt_inc   = {1'b0, cnt} + (ADDR_W+1)'(1);
        state_nxt = !en ? IDLE : start ? FILL :
                    (accept && state == FILL && cnt_inc == {1'b0, n_lat}) ? RUN : state;
    end

    // sample storage; the old word is read asynchronously in the same cycle it is overwritten
    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= din;
    end

    // control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            en_d    <= 1'b0;
            wptr    <= '0;
            cnt     <= '0;
            n_lat   <= ADDR_W'(1);
            wr      <= 1'b0;
            a       <= '0;
            b       <= '0;
            init_wr <= 1'b0;
            filled  <= 1'b0;
        end else begin
            en_d    <= en;
            state   <= state_nxt;
            filled  <= state_nxt == RUN;
            wr      <= accept;
            init_wr <= start;
            if (start) begin
                n_lat <= (win_len == '0) ? ADDR_W'(1) : win_len;
                wptr  <= '0;
                cnt   <= '0;
            end else if (accept) begin
                a    <= din;
                b    <= (state == RUN) ? mem[wptr] : '0;
                wptr <= wptr_nxt;
                if (state == FILL) cnt <= cnt_inc[ADDR_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_window_delay_line.sv
// tb_window_delay_line: randomized and directed checks against a queue-based window model
module tb_window_delay_line;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, clr = 1'b0, din_valid = 1'b0;
    logic [7:0]  win_len = '0;
    logic [15:0] din = '0;
    logic        wr, init_wr, filled;
    logic [15:0] a, b;
    logic [31:0] init_sum;
    logic [34:0] obs, mexp;

    int vectors = 0;
    int miscompares = 0;

    // model: the window is the last n accepted samples since the latest start
    logic [15:0] hist [$];
    bit          active, prev_en;
    int          m_n;
    logic        m_wr, m_init, m_filled;
    logic [15:0] m_a, m_b;

    window_delay_line dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .win_len(win_len),
        .din(din), .din_valid(din_valid), .wr(wr), .a(a), .b(b),
        .init_wr(init_wr), .init_sum(init_sum), .filled(filled)
    );

    always #5 clk = ~clk;

    assign obs  = {wr, init_wr, filled, a, b};
    assign mexp = {m_wr, m_init, m_filled, m_a, m_b};

    task automatic model_reset();
        hist.delete();
        active = 0; prev_en = 0; m_n = 1;
        m_wr = 0; m_init = 0; m_filled = 0; m_a = '0; m_b = '0;
    endtask

    // drive one cycle of inputs, advance the model, wait until after the edge
    task automatic step(input logic e, input logic c, input logic v, input logic [15:0] d, input logic [7:0] wl);
        en = e; clr = c; din_valid = v; din = d; win_len = wl;
        m_wr = 0; m_init = 0;
        if (!e) begin
            active = 0; m_filled = 0;
        end else if (c || (!active && !prev_en)) begin
            active = 1; m_n = (wl == 0) ? 1 : int'(wl); hist.delete();
            m_init = 1; m_filled = 0;
        end else if (active && v) begin
            m_wr = 1; m_a = d;
            m_b = (hist.size() == m_n) ? hist[0] : 16'h0;
            hist.push_back(d);
            if (hist.size() > m_n) void'(hist.pop_front());
            m_filled = hist.size() == m_n;
        end
        prev_en = e;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (obs !== 35'h0) begin miscompares++; $display("FAIL reset_outputs got=%h exp=%h", obs, 35'h0); end
        vectors++;
        if (init_sum !== 32'h0) begin miscompares++; $display("FAIL reset_init_sum got=%h exp=0", init_sum); end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        step(0, 0, 1, 16'h55, 4);
        vectors++;
        if (obs !== mexp) begin miscompares++; $display("FAIL reset_idle got=%h exp=%h", obs, mexp); end
    endtask

    task automatic test_fill_run();
        int ea [6] = '{1, 2, 3, 4, 5, 6};
        int eb [6] = '{0, 0, 0, 0, 1, 2};
        int sum = 0;
        step(1, 0, 0, 0, 4);
        vectors++;
        if (obs !== mexp || init_sum !== 32'h0) begin miscompares++; $display("FAIL fill_init got=%h exp=%h", obs, mexp); end
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 1, 16'(k + 1), 4);
            vectors++;
            if (obs !== mexp) begin miscompares++; $display("FAIL fill_model k=%0d got=%h exp=%h", k, obs, mexp); end
            vectors++;
            if (wr !== 1'b1 || a !== 16'(ea[k]) || b !== 16'(eb[k]) || filled !== (k >= 3)) begin
                miscompares++; $display("FAIL fill_pair k=%0d got a=%0d b=%0d filled=%0d exp a=%0d b=%0d", k, a, b, filled, ea[k], eb[k]);
            end
            sum += int'(a) - int'(b);
        end
        vectors++;
        if (sum !== 18) begin miscompares++; $display("FAIL fill_sum got=%0d exp=18", sum); end
    endtask

    task automatic test_gapped();
        int eb [6] = '{0, 0, 0, 0, 1, 2};
        step(0, 0, 0, 0, 4);
        step(1, 0, 0, 0, 4);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 1, 16'(k + 1), 4);
            vectors++;
            if (obs !== mexp || wr !== 1'b1 || b !== 16'(eb[k])) begin
                miscompares++; $display("FAIL gap_wr k=%0d got=%h exp=%h", k, obs, mexp);
            end
            for (int g = 0; g < 2; g++) begin
                step(1, 0, 0, 16'hdead, 4);
                vectors++;
                if (obs !== mexp || wr !== 1'b0) begin miscompares++; $display("FAIL gap_idle k=%0d got=%h exp=%h", k, obs, mexp); end
            end
        end
    endtask

    task automatic test_clr();
        int ein [8] = '{10, 20, 30, 40, 60, 70, 80, 90};
        step(0, 0, 0, 0, 3);
        step(1, 0, 0, 0, 3);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                step(1, 1, 1, 16'd50, 3);
                vectors++;
                if (obs !== mexp || init_wr !== 1'b1 || wr !== 1'b0) begin miscompares++; $display("FAIL clr_pulse got=%h exp=%h", obs, mexp); end
            end
            step(1, 0, 1, 16'(ein[k]), 3);
            vectors++;
            if (obs !== mexp) begin miscompares++; $display("FAIL clr_model k=%0d got=%h exp=%h", k, obs, mexp); end
        end
        vectors++;
        if (a !== 16'd90 || b !== 16'd60) begin miscompares++; $display("FAIL clr_last got a=%0d b=%0d exp a=90 b=60", a, b); end
    endtask

    task automatic test_edges();
        int eb [3] = '{0, 7, 8};
        for (int w = 1; w >= 0; w--) begin
            step(0, 0, 0, 0, 8'(w));
            step(1, 0, 0, 0, 8'(w));
            for (int k = 0; k < 3; k++) begin
                step(1, 0, 1, 16'(7 + k), 8'd5);
                vectors++;
                if (obs !== mexp || a !== 16'(7 + k) || b !== 16'(eb[k])) begin
                    miscompares++; $display("FAIL len%0d k=%0d got a=%0d b=%0d exp b=%0d", w, k, a, b, eb[k]);
                end
            end
        end
        step(0, 0, 0, 0, 255);
        step(1, 0, 0, 0, 255);
        for (int k = 1; k <= 300; k++) begin
            step(1, 0, 1, 16'(k), 255);
            vectors++;
            if (obs !== mexp || b !== ((k > 255) ? 16'(k - 255) : 16'h0)) begin
                miscompares++; $display("FAIL len255 k=%0d got=%h exp=%h", k, obs, mexp);
            end
        end
    endtask

    task automatic test_enable();
        step(0, 0, 1, 16'h1234, 2);
        vectors++;
        if (obs !== mexp || wr !== 1'b0 || filled !== 1'b0) begin miscompares++; $display("FAIL en_drop got=%h exp=%h", obs, mexp); end
        step(1, 0, 0, 0, 2);
        vectors++;
        if (obs !== mexp || init_wr !== 1'b1) begin miscompares++; $display("FAIL en_rise got=%h exp=%h", obs, mexp); end
        step(1, 0, 1, 16'h77, 2);
        vectors++;
        if (obs !== mexp || b !== 16'h0) begin miscompares++; $display("FAIL en_refill got=%h exp=%h", obs, mexp); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4; k++) step(1, 0, 1, 16'(100 + k), 2);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 35'h0) begin miscompares++; $display("FAIL async_reset got=%h exp=0", obs); end
        en = 1'b0; din_valid = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 16'(200 + k), 2);
            vectors++;
            if (obs !== mexp || wr !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle got=%h exp=%h", obs, mexp); end
        end
        step(1, 0, 1, 16'h9, 2);
        vectors++;
        if (obs !== mexp || init_wr !== 1'b1) begin miscompares++; $display("FAIL post_reset_start got=%h exp=%h", obs, mexp); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 19) != 0, $urandom_range(0, 39) == 0, 1'($urandom),
                 16'($urandom), 8'($urandom_range(0, 6)));
            vectors++;
            if (obs !== mexp) begin miscompares++; $display("FAIL random k=%0d got=%h exp=%h", k, obs, mexp); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_run();
        test_gapped();
        test_clr();
        test_edges();
        test_enable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/window_delay_line.md
Name: window_delay_line

Overview:
Upstream feeder for moving_sum in the gated integrator. It accepts a stream of ADC samples and holds the last N samples in a circular buffer. For every accepted sample it issues one moving_sum update: a = entering sample, b = sample leaving the window (zero while the window is still filling). It also produces the init_wr/init_sum pulse that clears the downstream accumulator at every (re)start.

Parameters:
DATA_W, 16, sample width; matches moving_sum a/b.
ADDR_W, 8, buffer address width; maximum window length is 2^ADDR_W - 1 samples.
INIT_W, 32, width of init_sum; matches moving_sum.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  level enable; a rising edge starts a window.
clr  input  1  single-cycle synchronous restart; the window is refilled from empty.
win_len  input  ADDR_W  window length N; latched at each start or clr.
din  input  DATA_W  input sample.
din_valid  input  1  din is valid this cycle.
wr  output  1  one-cycle update strobe to moving_sum.
a  output  DATA_W  entering sample.
b  output  DATA_W  leaving sample.
init_wr  output  1  one-cycle accumulator-clear strobe.
init_sum  output  INIT_W  accumulator initial value; always 0.
filled  output  1  high while in RUN (window full).

Behaviour:
- Reset (async, rst_n=0): wr=0, a=0, b=0, init_wr=0, init_sum=0, filled=0; state=IDLE; wptr=0; cnt=0; n_lat=1. Buffer contents are not reset. They are never read before being written in the current window.
- States: IDLE, FILL, RUN. All outputs are registered.
- IDLE: din_valid is ignored and wr=0.
  - A rising edge of en (en=1 now, en=0 in the previous cycle) moves to FILL. On that edge: latch n_lat=win_len (0 is treated as 1), wptr=0, cnt=0, and pulse init_wr=1 with init_sum=0 on the next cycle.
- Any state with en=0: go to IDLE next cycle; filled=0; no wr.
- clr=1 with en=1 (any state): same actions as start, i.e. relatch win_len, reset pointers, pulse init_wr, go to FILL.
  - clr has priority over din_valid in the same cycle; that sample is dropped with no wr.
- FILL, din_valid=1:
  - write din to mem[wptr];
  - next cycle: wr=1, a=din, b=0;
  - cnt++, wptr advances;
  - when cnt reaches n_lat, go to RUN.
- RUN, din_valid=1:
  - read mem[wptr] (the sample written exactly n_lat accepted samples earlier) before overwriting it with din (read-before-write at the same address);
  - next cycle: wr=1, a=din, b=old mem[wptr];
  - wptr advances.
- Pointer wrap: wptr goes from n_lat-1 to 0. With n_lat=1, wptr stays at 0 and b equals the previous sample.
- Latency: exactly 1 clock from din_valid to wr. Back-to-back din_valid every cycle is supported at full rate.
- init_wr and wr are never high in the same cycle: the start/clr cycle accepts no sample.
- win_len changes outside start/clr are ignored.
- filled = (state==RUN), registered.
- Storage: register array or distributed RAM with asynchronous read, depth 2^ADDR_W.
- Reset mid-window: everything returns to the reset state at once. Resuming needs a fresh en rising edge after rst_n is released.

Test Plan:
- Fill and run: reset, win_len=4, en rises, din_valid each cycle with din=1..6 -> one init_wr pulse with init_sum=0, then wr pairs (a,b) = (1,0),(2,0),(3,0),(4,0),(5,1),(6,2). filled goes high the cycle after sample 4 is accepted. A downstream moving_sum reads 18.
- Gapped input: same as the first scenario, but din_valid only every third cycle -> identical a/b sequence; each wr exactly 1 cycle after its din_valid; wr=0 elsewhere.
- clr mid-run: win_len=3, samples 10,20,30,40, then clr together with din_valid (din=50), then din=60,70,80,90 -> 50 dropped; init_wr pulses; pairs after clr are (60,0),(70,0),(80,0),(90,60).
- Window edge cases: win_len=1, din=7,8,9 -> pairs (7,0),(8,7),(9,8). win_len=0 behaves identically. win_len=255 with 300 samples of din=k -> b=k-255 for k>255, covering the wrap.
- Enable/reset: deassert en in RUN -> wr=0, filled=0 next cycle. Re-raising en -> fresh FILL with b=0 and a new init_wr. Pulse rst_n low mid-RUN asynchronously -> all outputs 0 immediately. din_valid after release is ignored until an en rising edge.
